router_fsm_nch: RTL
===================

# router_fsm_nch

Parametrised successor of the 1x3 router control FSM: sequences header decode, payload load, FIFO-full stall, parity load and parity check for a router with NUM_CH output channels. It sits between the input register/parity block and the per-channel output FIFOs, driving the same state strobes as before. It adds three behaviours:
- a latched destination channel;
- per-channel soft reset qualified by that channel;
- an explicit drop path for invalid addresses and wait timeouts.

## Interface
Parameters:
- NUM_CH, 3, number of output channels (2..16)
- ADDR_W, $clog2(NUM_CH), header address field width
- WAIT_TIMEOUT, 255, max cycles in WAIT_TILL_EMPTY before drop (1..65535)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet valid from source
- data_in  in  ADDR_W  header address field
- parity_done  in  1  parity byte already captured
- low_pkt_valid  in  1  pkt_valid fell during FIFO-full stall
- fifo_full  in  1  selected FIFO full
- fifo_empty  in  NUM_CH  per-channel FIFO empty
- soft_reset  in  NUM_CH  per-channel read-timeout soft reset
- busy, detect_add, ld_state, laf_state, full_state, lfd_state, write_enb_reg, rst_int_reg  out  1 each  state strobes
- drop_state  out  1  packet being discarded
- timeout_err  out  1  one-cycle pulse on wait timeout
- cur_ch  out  ADDR_W  latched destination channel

## Operation
States (4-bit encoding): DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET. Unused encodings go to DECODE_ADDRESS.

Strobes are Moore outputs decoded from state:
- DECODE_ADDRESS: detect_add
- LOAD_FIRST_DATA: lfd_state, busy
- LOAD_DATA: ld_state, write_enb_reg
- LOAD_PARITY: busy, ld_state, write_enb_reg
- CHECK_PARITY_ERROR: rst_int_reg, busy
- FIFO_FULL_STATE: full_state, busy
- LOAD_AFTER_FULL: laf_state, busy, write_enb_reg
- WAIT_TILL_EMPTY: busy
- DROP_PACKET: drop_state (busy=0, so the source keeps streaming and the payload is discarded)

Transitions out of DECODE_ADDRESS, only when pkt_valid=1 (cur_ch <= data_in captured on the same edge):
- data_in >= NUM_CH -> DROP_PACKET
- fifo_empty[data_in]=1 -> LOAD_FIRST_DATA
- otherwise -> WAIT_TILL_EMPTY

Other transitions:
- LOAD_FIRST_DATA -> LOAD_DATA
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- LOAD_PARITY -> CHECK_PARITY_ERROR
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty[cur_ch] -> LOAD_FIRST_DATA. This uses the latched channel, never live data_in.
- DROP_PACKET: !pkt_valid -> DECODE_ADDRESS.

Soft reset:
- soft_reset[cur_ch]=1 in any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle.
- Soft reset of any other channel is ignored.
- In DECODE_ADDRESS, soft_reset has no effect.

Priority: reset > soft_reset[cur_ch] > normal transition.

## Timing
- reset: state=DECODE_ADDRESS, cur_ch=0, wait counter=0, timeout_err=0. Outputs then read detect_add=1 and all other strobes 0.
- Reset mid-packet returns to DECODE_ADDRESS on the next edge with no further write_enb_reg.
- Header accepted at edge N (pkt_valid=1 in DECODE_ADDRESS) -> lfd_state=1 in cycle N+1 and ld_state=1 in N+2.
- Strobes change only at clock edges, with zero-cycle decode from state. No output glitches across states.
- cur_ch changes only on header acceptance and holds through soft reset.
- Wait counter: cleared on entry to WAIT_TILL_EMPTY; increments each cycle while there; saturates at WAIT_TIMEOUT.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.

## Configuration
- ROUTER_FSM_TIMEOUT_EN defined:
  - WAIT_TILL_EMPTY with counter==WAIT_TIMEOUT and fifo_empty[cur_ch]=0 -> DROP_PACKET.
  - timeout_err pulses high for exactly the cycle of that transition.
  - fifo_empty on the same cycle wins (-> LOAD_FIRST_DATA, no pulse).
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; timeout_err tied 0.

## Test plan
- NUM_CH=4: reset, header data_in=2 with fifo_empty=4'b1111, 5 payload cycles, pkt_valid low -> path DECODE→LFD→LD×5→LOAD_PARITY→CHECK_PARITY→DECODE; cur_ch=2.
- Header data_in=1 with fifo_empty[1]=0; data_in changed to 0 while waiting; fifo_empty[1] set after 10 cycles -> stays in WAIT 10 cycles, then LFD; cur_ch stays 1.
- fifo_full asserted for 3 cycles in LOAD_DATA, low_pkt_valid=1 on release -> FULL×3, LAF, LOAD_PARITY.
- NUM_CH=3, header data_in=3 -> DROP_PACKET, busy=0, drop_state=1 until pkt_valid falls, then DECODE_ADDRESS.
- In LOAD_DATA with cur_ch=0: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE_ADDRESS next cycle.
- With ROUTER_FSM_TIMEOUT_EN and WAIT_TIMEOUT=8, fifo_empty never set -> DROP_PACKET after 8 wait cycles, timeout_err high for 1 cycle.

Source files
------------

// File: rtl/router_fsm_nch.sv
// router_fsm_nch - control FSM for a 1xNUM_CH packet router.
//   Sequences header decode, payload load, FIFO-full stall, parity load and
//   parity check; latches the destination channel, honours soft reset only for
//   that channel, and discards packets with an invalid address.
//   Optional feature macro: ROUTER_FSM_TIMEOUT_EN (drop after WAIT_TIMEOUT
//   cycles in WAIT_TILL_EMPTY and pulse o_timeout_err); default build waits forever.
// Ports:
//   i_clock, i_reset (sync, active-high)
//   i_pkt_valid, i_data_in[ADDR_W], i_parity_done, i_low_pkt_valid, i_fifo_full
//   i_fifo_empty[NUM_CH], i_soft_reset[NUM_CH]
//   o_busy, o_detect_add, o_ld_state, o_laf_state, o_full_state, o_lfd_state,
//   o_write_enb_reg, o_rst_int_reg, o_drop_state  : Moore state strobes
//   o_timeout_err : registered one-cycle pulse on wait timeout
//   o_cur_ch[ADDR_W] : latched destination channel
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = $clog2(NUM_CH),
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_pkt_valid,
  input  logic [ADDR_W-1:0] i_data_in,
  input  logic              i_parity_done,
  input  logic              i_low_pkt_valid,
  input  logic              i_fifo_full,
  input  logic [NUM_CH-1:0] i_fifo_empty,
  input  logic [NUM_CH-1:0] i_soft_reset,
  output logic              o_busy,
  output logic              o_detect_add,
  output logic              o_ld_state,
  output logic              o_laf_state,
  output logic              o_full_state,
  output logic              o_lfd_state,
  output logic              o_write_enb_reg,
  output logic              o_rst_int_reg,
  output logic              o_drop_state,
  output logic              o_timeout_err,
  output logic [ADDR_W-1:0] o_cur_ch
);

  typedef enum logic [3:0] {
    S_DECODE_ADDRESS     = 4'd0,
    S_LOAD_FIRST_DATA    = 4'd1,
    S_LOAD_DATA          = 4'd2,
    S_FIFO_FULL_STATE    = 4'd3,
    S_LOAD_AFTER_FULL    = 4'd4,
    S_LOAD_PARITY        = 4'd5,
    S_CHECK_PARITY_ERROR = 4'd6,
    S_WAIT_TILL_EMPTY    = 4'd7,
    S_DROP_PACKET        = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_ch;
  logic              w_hdr_bad;
  logic              w_hdr_empty;
  logic              w_cur_empty;
  logic              w_cur_sreset;
  logic              w_hdr_accept;

  // Channel selects are built with a bounded loop so an out-of-range address
  // (NUM_CH not a power of two) reads as "not empty / no soft reset" instead
  // of indexing past the vector.
  always_comb begin
    w_hdr_empty  = 1'b0;
    w_cur_empty  = 1'b0;
    w_cur_sreset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_data_in == ADDR_W'(i)) w_hdr_empty  = i_fifo_empty[i];
      if (r_cur_ch  == ADDR_W'(i)) w_cur_empty  = i_fifo_empty[i];
      if (r_cur_ch  == ADDR_W'(i)) w_cur_sreset = i_soft_reset[i];
    end
  end

  assign w_hdr_bad    = ({1'b0, i_data_in} >= (ADDR_W+1)'(NUM_CH));
  assign w_hdr_accept = (r_state == S_DECODE_ADDRESS) && i_pkt_valid;

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;
  logic        w_timeout;
  logic        w_timeout_fire;

  assign w_timeout      = (r_wait_cnt == 16'(WAIT_TIMEOUT));
  // Soft reset and a freshly emptied FIFO both outrank the timeout.
  assign w_timeout_fire = (r_state == S_WAIT_TILL_EMPTY) && !w_cur_sreset &&
                          !w_cur_empty && w_timeout;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_fire;
      if (r_state != S_WAIT_TILL_EMPTY)
        r_wait_cnt <= '0;
      else if (!w_timeout)
        r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_DECODE_ADDRESS;
      r_cur_ch <= '0;
    end else begin
      r_state <= w_next;
      if (w_hdr_accept) r_cur_ch <= i_data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_DECODE_ADDRESS && w_cur_sreset) begin
      w_next = S_DECODE_ADDRESS;
    end else begin
      case (r_state)
        S_DECODE_ADDRESS: begin
          if (i_pkt_valid) begin
            if (w_hdr_bad)        w_next = S_DROP_PACKET;
            else if (w_hdr_empty) w_next = S_LOAD_FIRST_DATA;
            else                  w_next = S_WAIT_TILL_EMPTY;
          end
        end
        S_LOAD_FIRST_DATA: w_next = S_LOAD_DATA;
        S_LOAD_DATA: begin
          if (i_fifo_full)       w_next = S_FIFO_FULL_STATE;
          else if (!i_pkt_valid) w_next = S_LOAD_PARITY;
        end
        S_LOAD_PARITY: w_next = S_CHECK_PARITY_ERROR;
        S_CHECK_PARITY_ERROR: begin
          if (i_fifo_full) w_next = S_FIFO_FULL_STATE;
          else             w_next = S_DECODE_ADDRESS;
        end
        S_FIFO_FULL_STATE: begin
          if (!i_fifo_full) w_next = S_LOAD_AFTER_FULL;
        end
        S_LOAD_AFTER_FULL: begin
          if (i_parity_done)        w_next = S_DECODE_ADDRESS;
          else if (i_low_pkt_valid) w_next = S_LOAD_PARITY;
          else                      w_next = S_LOAD_DATA;
        end
        S_WAIT_TILL_EMPTY: begin
          // Uses the latched channel; the source may already be driving
          // something else on i_data_in.
          if (w_cur_empty) w_next = S_LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_TIMEOUT_EN
          else if (w_timeout) w_next = S_DROP_PACKET;
`endif
        end
        S_DROP_PACKET: begin
          if (!i_pkt_valid) w_next = S_DECODE_ADDRESS;
        end
        default: w_next = S_DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    o_busy          = 1'b0;
    o_detect_add    = 1'b0;
    o_ld_state      = 1'b0;
    o_laf_state     = 1'b0;
    o_full_state    = 1'b0;
    o_lfd_state     = 1'b0;
    o_write_enb_reg = 1'b0;
    o_rst_int_reg   = 1'b0;
    o_drop_state    = 1'b0;
    case (r_state)
      S_DECODE_ADDRESS:     o_detect_add = 1'b1;
      S_LOAD_FIRST_DATA:    begin o_lfd_state = 1'b1; o_busy = 1'b1; end
      S_LOAD_DATA:          begin o_ld_state = 1'b1; o_write_enb_reg = 1'b1; end
      S_LOAD_PARITY:        begin o_busy = 1'b1; o_ld_state = 1'b1; o_write_enb_reg = 1'b1; end
      S_CHECK_PARITY_ERROR: begin o_rst_int_reg = 1'b1; o_busy = 1'b1; end
      S_FIFO_FULL_STATE:    begin o_full_state = 1'b1; o_busy = 1'b1; end
      S_LOAD_AFTER_FULL:    begin o_laf_state = 1'b1; o_busy = 1'b1; o_write_enb_reg = 1'b1; end
      S_WAIT_TILL_EMPTY:    o_busy = 1'b1;
      S_DROP_PACKET:        o_drop_state = 1'b1;
      default:              o_detect_add = 1'b1;
    endcase
  end

  assign o_cur_ch = r_cur_ch;

endmodule
